jstk_spi_poller: RTL

SPI master that periodically polls the PmodJSTK joystick and presents its latest X/Y position and button state as registered outputs. It sits directly upstream of the seven-segment display controller: `X_POS` or `Y_POS`, zero-extended to 11 bits, drives the controller's `DIN`. Each 5-byte SPI transaction also writes the two joystick LEDs.

---
 rtl/jstk_spi_poller.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/jstk_spi_poller.sv
// jstk_spi_poller: SPI master (mode 0) that polls a PmodJSTK joystick every
// POLL_PERIOD cycles with a 5-byte transaction and presents the latest
// position and button state as registered outputs.
//
// Ports:
//   CLK    in   system clock
//   RST    in   synchronous active-high reset
//   LED    in   [1:0] LED state, latched at transaction start
//   MISO   in   serial data from the joystick
//   SS     out  slave select, active low
//   SCLK   out  SPI clock, idles low
//   MOSI   out  serial data to the joystick
//   X_POS  out  [9:0] last X position
//   Y_POS  out  [9:0] last Y position
//   BTN    out  [2:0] last button state {BTN2, BTN1, stick}
//   VALID  out  one-cycle pulse when X_POS/Y_POS/BTN update
//   BUSY   out  high while SS is low
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | SS high, waiting for a poll tick
// SETUP  | SS low, SS_SETUP cycles before the first bit
// BIT_LO | SCLK low for CLK_DIV cycles, MOSI presents current TX MSB
// BIT_HI | SCLK high for CLK_DIV cycles, MISO sampled on the first cycle
// GAP    | SCLK low for BYTE_GAP cycles between bytes
// DONE   | one cycle: raise SS, publish outputs, pulse VALID

module jstk_spi_poller #(
  parameter int CLK_DIV     = 750,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 5_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] LED,
  input  logic       MISO,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  output logic [9:0] X_POS,
  output logic [9:0] Y_POS,
  output logic [2:0] BTN,
  output logic       VALID,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_BIT_LO, S_BIT_HI, S_GAP, S_DONE
  } state_t;

  state_t      state;
  logic [31:0] poll_cnt;
  logic        tick;
  logic [31:0] tmr;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic [1:0]  led_q;
  logic [7:0]  rx0;
  logic [1:0]  rx1;
  logic [7:0]  rx2;
  logic [1:0]  rx3;
  logic [2:0]  rx4;

  // MOSI is the MSB of the TX shift register, so it is already a flop output.
  assign MOSI = tx_sr[7];

  // Free-running poll counter; tick is registered at the wrap so the FSM
  // reacts one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      poll_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick <= (poll_cnt == 32'(POLL_PERIOD - 1));
      if (poll_cnt == 32'(POLL_PERIOD - 1)) poll_cnt <= '0;
      else                                  poll_cnt <= poll_cnt + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      tmr      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      led_q    <= '0;
      rx0      <= '0;
      rx1      <= '0;
      rx2      <= '0;
      rx3      <= '0;
      rx4      <= '0;
      SS       <= 1'b1;
      SCLK     <= 1'b0;
      X_POS    <= '0;
      Y_POS    <= '0;
      BTN      <= '0;
      VALID    <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            led_q <= LED;
            SS    <= 1'b0;
            BUSY  <= 1'b1;
            tmr   <= 32'(SS_SETUP - 1);
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr == '0) begin
            tx_sr    <= {6'b100000, led_q};
            bit_idx  <= '0;
            byte_idx <= '0;
            tmr      <= 32'(CLK_DIV - 1);
            state    <= S_BIT_LO;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_BIT_LO: begin
          if (tmr == '0) begin
            SCLK  <= 1'b1;
            tmr   <= 32'(CLK_DIV - 1);
            state <= S_BIT_HI;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_BIT_HI: begin
          // First cycle of the high phase is the cycle SCLK rose.
          if (tmr == 32'(CLK_DIV - 1)) rx_sr <= {rx_sr[6:0], MISO};
          if (tmr == '0) begin
            SCLK <= 1'b0;
            if (bit_idx != 3'd7) begin
              tx_sr   <= {tx_sr[6:0], 1'b0};
              bit_idx <= bit_idx + 3'd1;
              tmr     <= 32'(CLK_DIV - 1);
              state   <= S_BIT_LO;
            end else begin
              // Only the position and button bits are kept.
              case (byte_idx)
                3'd0:    rx0 <= rx_sr;
                3'd1:    rx1 <= rx_sr[1:0];
                3'd2:    rx2 <= rx_sr;
                3'd3:    rx3 <= rx_sr[1:0];
                default: rx4 <= rx_sr[2:0];
              endcase
              bit_idx <= '0;
              if (byte_idx != 3'd4) begin
                byte_idx <= byte_idx + 3'd1;
                tmr      <= 32'(BYTE_GAP - 1);
                state    <= S_GAP;
              end else begin
                state <= S_DONE;
              end
            end
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_GAP: begin
          if (tmr == '0) begin
            tx_sr <= 8'h00;
            tmr   <= 32'(CLK_DIV - 1);
            state <= S_BIT_LO;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_DONE: begin
          SS       <= 1'b1;
          BUSY     <= 1'b0;
          VALID    <= 1'b1;
          X_POS    <= {rx1, rx0};
          Y_POS    <= {rx3, rx2};
          BTN      <= rx4;
          tx_sr    <= 8'h00;
          byte_idx <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
